fetch_queue: RTL and testbench

//  Instruction prefetch queue between the instruction memory port and the IF/ID pipeline register.
//  - Owns the fetch PC and issues word fetches over a req/gnt/rvalid handshake.
//  - Buffers returned words with their PC+4 in a small FIFO.
//  - The IF/ID register pops the FIFO while ifidWrite is high.
//  - A branch/jump redirect from ID flushes the queue and restarts fetch at the new PC.

---
 rtl/mips_pkg.sv | 9 +
 rtl/fq_fifo.sv | 57 +++++
 rtl/fetch_queue.sv | 144 ++++++++++++++
 tb/tb_fetch_queue.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction fetch front end.
package mips_pkg;

    typedef enum logic [1:0] {FQ_IDLE, FQ_REQ, FQ_WAIT, FQ_DROP} fq_state_t;

    localparam int WORD_W = 32;
    localparam int PC_INC = 4;

endpackage

// File: rtl/fq_fifo.sv
// Circular buffer holding {pc_plus4, inst} entries for the fetch queue.
// flush empties the buffer and has priority over push and pop.
module fq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    // A pop against an empty buffer is ignored rather than underflowing.
    assign pop_ok  = pop && (count != '0) && !flush;
    assign push_ok = push && !flush;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, issues single-outstanding fetches,
// buffers responses for IF/ID. Optional same-cycle bypass when empty: FQ_BYPASS_EN.
module fetch_queue
    import mips_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              deq,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_pc_plus4,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int                CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

    fq_state_t                state;
    fq_state_t                state_next;
    logic [ADDR_W-1:0]        fetch_pc;
    logic [ADDR_W-1:0]        fetch_pc_next;
    logic [ADDR_W-1:0]        entry_pc;
    logic [CNT_W-1:0]         count;
    logic [CNT_W-1:0]         count_next;
    logic                     resp_ok;
    logic                     push;
    logic                     pop;
    logic                     head_valid;
    logic [ADDR_W+DATA_W-1:0] head;

    function automatic logic [ADDR_W-1:0] pc_add(input logic [ADDR_W-1:0] pc);
        return pc + ADDR_W'(PC_INC);
    endfunction

    // A response is kept only if it answers the live request and no redirect kills it.
    assign resp_ok    = (state == FQ_WAIT) && mem_rvalid && !redirect;
    assign pop        = deq && (count != '0) && !redirect;
    assign head_valid = (count != '0);

`ifdef FQ_BYPASS_EN
    logic bypass_hit;
    assign bypass_hit = resp_ok && (count == '0);
    // A bypassed word consumed in the same cycle never enters storage.
    assign push       = resp_ok && !(bypass_hit && deq);
`else
    assign push       = resp_ok;
`endif

    assign count_next = redirect ? '0 : (count + CNT_W'(push) - CNT_W'(pop));

    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        if (redirect) begin
            fetch_pc_next = {redirect_pc[ADDR_W-1:2], 2'b00};
        end
        case (state)
            FQ_IDLE: begin
                if (count < FULL) begin
                    state_next = FQ_REQ;
                end
            end
            FQ_REQ: begin
                if (mem_gnt) begin
                    state_next = redirect ? FQ_DROP : FQ_WAIT;
                    if (!redirect) begin
                        fetch_pc_next = pc_add(fetch_pc);
                    end
                end
            end
            FQ_WAIT: begin
                if (redirect) begin
                    state_next = mem_rvalid ? FQ_IDLE : FQ_DROP;
                end else if (mem_rvalid) begin
                    state_next = (count_next < FULL) ? FQ_REQ : FQ_IDLE;
                end
            end
            FQ_DROP: begin
                if (mem_rvalid) begin
                    state_next = FQ_IDLE;
                end
            end
            default: state_next = FQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FQ_IDLE;
            fetch_pc <= RESET_PC;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
        end
    end

    // PC of the word in flight; only meaningful while in WAIT.
    always_ff @(posedge clk) begin
        if (state == FQ_REQ && mem_gnt) begin
            entry_pc <= fetch_pc;
        end
    end

    fq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .din   ({pc_add(entry_pc), mem_rdata}),
        .head  (head),
        .count (count)
    );

    assign mem_req  = (state == FQ_REQ);
    assign mem_addr = fetch_pc;

`ifdef FQ_BYPASS_EN
    assign out_valid    = head_valid || bypass_hit;
    assign out_inst     = head_valid ? head[DATA_W-1:0] :
                          (bypass_hit ? mem_rdata : '0);
    assign out_pc_plus4 = head_valid ? head[ADDR_W+DATA_W-1:DATA_W] :
                          (bypass_hit ? pc_add(entry_pc) : '0);
`else
    assign out_valid    = head_valid;
    assign out_inst     = head_valid ? head[DATA_W-1:0] : '0;
    assign out_pc_plus4 = head_valid ? head[ADDR_W+DATA_W-1:DATA_W] : '0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed table-driven bench for fetch_queue plus hand-written wrap/bypass/reset sequences.
module tb_fetch_queue;

`ifdef FQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        deq;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc_plus4;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    fetch_queue #(
        .DEPTH    (4),
        .ADDR_W   (32),
        .DATA_W   (32),
        .RESET_PC (32'h0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .deq          (deq),
        .out_valid    (out_valid),
        .out_inst     (out_inst),
        .out_pc_plus4 (out_pc_plus4),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic [31:0] rpc;
        logic        d;
        logic        g;
        logic        rv;
        logic [31:0] rd;
        logic        ev;
        logic [31:0] ei;
        logic [31:0] ep;
        logic        er;
        logic [31:0] ea;
    } vec_t;

    localparam int NV = 33;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic r, input logic [31:0] rpc, input logic d,
                                input logic g, input logic rv, input logic [31:0] rd,
                                input logic ev, input logic [31:0] ei, input logic [31:0] ep,
                                input logic er, input logic [31:0] ea);
        vec_t v;
        v.r = r; v.rpc = rpc; v.d = d; v.g = g; v.rv = rv; v.rd = rd;
        v.ev = ev; v.ei = ei; v.ep = ep; v.er = er; v.ea = ea;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ev, input logic [31:0] ei,
                           input logic [31:0] ep, input logic er, input logic [31:0] ea);
        chk({tag, " out_valid"}, 32'(out_valid), 32'(ev));
        chk({tag, " out_inst"}, out_inst, ei);
        chk({tag, " out_pc_plus4"}, out_pc_plus4, ep);
        chk({tag, " mem_req"}, 32'(mem_req), 32'(er));
        chk({tag, " mem_addr"}, mem_addr, ea);
    endtask

    task automatic drive(input logic r, input logic [31:0] rpc, input logic d,
                         input logic g, input logic rv, input logic [31:0] rd);
        redirect = r; redirect_pc = rpc; deq = d; mem_gnt = g; mem_rvalid = rv; mem_rdata = rd;
    endtask

    localparam logic [31:0] D0 = 32'h1000_0001, D1 = 32'h1000_0002;
    localparam logic [31:0] D2 = 32'h1000_0003, D3 = 32'h1000_0004;
    localparam logic [31:0] E0 = 32'h2000_0001, F0 = 32'h3000_0001;
    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    initial begin
        // Fill to four entries with gnt always high, then drain / push+deq
        vecs[0]  = mk(0, 0, 0, 1, 0, 0,    0, 0, 0, 1, 32'h0);
        vecs[1]  = mk(0, 0, 0, 1, 1, D0,   BYP, BYP ? D0 : 32'h0, BYP ? 32'h4 : 32'h0, 0, 32'h4);
        vecs[2]  = mk(0, 0, 0, 1, 0, 0,    1, D0, 32'h4, 1, 32'h4);
        vecs[3]  = mk(0, 0, 0, 1, 1, D1,   1, D0, 32'h4, 0, 32'h8);
        vecs[4]  = mk(0, 0, 0, 1, 0, 0,    1, D0, 32'h4, 1, 32'h8);
        vecs[5]  = mk(0, 0, 0, 1, 1, D2,   1, D0, 32'h4, 0, 32'hC);
        vecs[6]  = mk(0, 0, 0, 1, 0, 0,    1, D0, 32'h4, 1, 32'hC);
        vecs[7]  = mk(0, 0, 0, 1, 1, D3,   1, D0, 32'h4, 0, 32'h10);
        vecs[8]  = mk(0, 0, 0, 1, 0, 0,    1, D0, 32'h4, 0, 32'h10);
        vecs[9]  = mk(0, 0, 0, 1, 0, 0,    1, D0, 32'h4, 0, 32'h10);
        vecs[10] = mk(0, 0, 1, 0, 0, 0,    1, D0, 32'h4, 0, 32'h10);
        vecs[11] = mk(0, 0, 0, 0, 0, 0,    1, D1, 32'h8, 0, 32'h10);
        vecs[12] = mk(0, 0, 0, 1, 0, 0,    1, D1, 32'h8, 1, 32'h10);
        vecs[13] = mk(0, 0, 1, 0, 0, 0,    1, D1, 32'h8, 0, 32'h14);
        vecs[14] = mk(0, 0, 1, 0, 0, 0,    1, D2, 32'hC, 0, 32'h14);
        vecs[15] = mk(0, 0, 1, 0, 1, E0,   1, D3, 32'h10, 0, 32'h14);
        vecs[16] = mk(0, 0, 0, 0, 0, 0,    1, E0, 32'h14, 1, 32'h14);
        // Redirect to 0x40 while waiting; late response must be dropped
        vecs[17] = mk(0, 0, 0, 1, 0, 0,    1, E0, 32'h14, 1, 32'h14);
        vecs[18] = mk(1, 32'h40, 0, 0, 0, 0, 1, E0, 32'h14, 0, 32'h18);
        vecs[19] = mk(0, 0, 0, 0, 1, JUNK, 0, 0, 0, 0, 32'h40);
        vecs[20] = mk(0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 32'h40);
        vecs[21] = mk(0, 0, 0, 1, 0, 0,    0, 0, 0, 1, 32'h40);
        vecs[22] = mk(0, 0, 0, 0, 1, F0,   BYP, BYP ? F0 : 32'h0, BYP ? 32'h44 : 32'h0, 0, 32'h44);
        vecs[23] = mk(0, 0, 0, 0, 0, 0,    1, F0, 32'h44, 1, 32'h44);
        // Redirect to 0x80 coinciding with a grant
        vecs[24] = mk(1, 32'h80, 0, 1, 0, 0, 1, F0, 32'h44, 1, 32'h44);
        vecs[25] = mk(0, 0, 0, 0, 1, JUNK, 0, 0, 0, 0, 32'h80);
        vecs[26] = mk(0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 32'h80);
        vecs[27] = mk(0, 0, 0, 0, 0, 0,    0, 0, 0, 1, 32'h80);
        // Ungranted request retargets; redirect with rvalid in WAIT discards data
        vecs[28] = mk(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 1, 32'h80);
        vecs[29] = mk(0, 0, 0, 1, 0, 0,    0, 0, 0, 1, 32'h100);
        vecs[30] = mk(1, 32'h200, 0, 0, 1, JUNK, 0, 0, 0, 0, 32'h104);
        vecs[31] = mk(0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 32'h200);
        vecs[32] = mk(0, 0, 0, 0, 0, 0,    0, 0, 0, 1, 32'h200);

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk_all("reset", 0, 0, 0, 0, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].r, vecs[i].rpc, vecs[i].d, vecs[i].g, vecs[i].rv, vecs[i].rd);
            #1;
            chk_all($sformatf("row%0d", i), vecs[i].ev, vecs[i].ei, vecs[i].ep,
                    vecs[i].er, vecs[i].ea);
        end

        // PC wrap at the top of the address space plus empty-queue response timing
        @(negedge clk);
        drive(1, 32'hFFFF_FFFC, 0, 0, 0, 0);
        #1;
        chk_all("wrap_redirect", 0, 0, 0, 1, 32'h200);
        @(negedge clk);
        drive(0, 0, 0, 1, 0, 0);
        #1;
        chk_all("wrap_req", 0, 0, 0, 1, 32'hFFFF_FFFC);
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 32'h2008_000A);
        #1;
        chk_all("empty_rvalid", BYP, BYP ? 32'h2008_000A : 32'h0, 32'h0, 0, 32'h0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk_all("after_rvalid", 1, 32'h2008_000A, 32'h0, 1, 32'h0);

        // Asynchronous reset in the middle of a cycle with a queued entry
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_all("rst_release", 0, 0, 0, 0, 32'h0);
        @(negedge clk);
        #1;
        chk_all("first_req", 0, 0, 0, 1, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
